// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Lets NUM_REQ byte sources share one UART transmitter. Grants rotate
//   round-robin. An owner may keep the grant for up to MAX_BURST consecutive
//   bytes. Each byte is handed over with a one-cycle tx_start, and the arbiter
//   then waits for tx_done. A byte that never completes is aborted after
//   TIMEOUT_CYCLES and reported on err_timeout.
//
//   Handshake: req_valid[i] with req_data[8i+7:8i] is a pending byte. The
//   source holds both stable until it sees req_ready[i]. req_ready is a
//   one-cycle, at-most-one-hot pulse, raised in the same cycle as tx_start.
//   That pulse means the byte has been taken. In the following cycle the
//   source either drops valid or presents its next byte. A source may also
//   withdraw valid without a ready; it is then simply not granted.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int MAX_BURST      = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_start,
    input  logic                       tx_busy,
    input  logic                       tx_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       active,
    output logic                       err_timeout,
    output logic                       dbg_state_o
);

    localparam int              GW        = $clog2(NUM_REQ);
    localparam logic [7:0]      BURST_MAX = 8'(MAX_BURST);
    localparam logic [15:0]     WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0]   LAST_INIT = GW'(NUM_REQ - 1);
    localparam logic [GW:0]     NUM_REQ_W = (GW+1)'(NUM_REQ);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           burst_cnt_q, burst_cnt_d;
    logic [15:0]          wait_cnt_q, wait_cnt_d;
    logic [GW-1:0]        last_grant_q, last_grant_d;
    logic [GW-1:0]        grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d;
    logic                 active_q, active_d;
    logic                 err_timeout_q, err_timeout_d;

    logic                 locked;
    logic                 rr_found;
    logic [GW-1:0]        rr_idx;
    logic [GW:0]          scan;
    logic [GW-1:0]        win_idx;

    // Choose the winner. The owner keeps the grant while it still has data
    // and its burst is neither exhausted nor unstarted (burst_cnt == 0 right
    // after reset). In every other case the search runs round-robin, starting
    // just after the last grant.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        scan     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan = {1'b0, last_grant_q} + (GW+1)'(k);
            if (scan >= NUM_REQ_W) begin
                scan = scan - NUM_REQ_W;
            end
            if (!rr_found && req_valid[scan[GW-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = scan[GW-1:0];
            end
        end
        locked  = (burst_cnt_q != 8'd0) && (burst_cnt_q < BURST_MAX) &&
                  req_valid[last_grant_q];
        win_idx = locked ? last_grant_q : rr_idx;
    end

    // Next state and next registered outputs of the IDLE/WAIT sequencer.
    always_comb begin
        state_d       = state_q;
        burst_cnt_d   = burst_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        last_grant_d  = last_grant_q;
        grant_id_d    = grant_id_q;
        tx_data_d     = tx_data_q;
        active_d      = active_q;
        tx_start_d    = 1'b0;
        req_ready_d   = '0;
        err_timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // tx_done is ignored here. A busy transmitter holds every grant back.
                if ((|req_valid) && !tx_busy) begin
                    tx_data_d            = req_data[{win_idx, 3'b000} +: 8];
                    tx_start_d           = 1'b1;
                    req_ready_d[win_idx] = 1'b1;
                    grant_id_d           = win_idx;
                    last_grant_d         = win_idx;
                    active_d             = 1'b1;
                    wait_cnt_d           = '0;
                    burst_cnt_d          = locked ? (burst_cnt_q + 8'd1) : 8'd1;
                    state_d              = S_WAIT;
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + 16'd1;
                if (tx_done) begin
                    // Completion beats a timeout that falls in the same cycle.
                    active_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // Abort the byte. A full burst count forces the next grant round-robin.
                    err_timeout_d = 1'b1;
                    active_d      = 1'b0;
                    burst_cnt_d   = BURST_MAX;
                    state_d       = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers. Reset drops any byte in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            burst_cnt_q   <= 8'd0;
            wait_cnt_q    <= 16'd0;
            last_grant_q  <= LAST_INIT;
            grant_id_q    <= '0;
            req_ready_q   <= '0;
            tx_data_q     <= 8'd0;
            tx_start_q    <= 1'b0;
            active_q      <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            burst_cnt_q   <= burst_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            last_grant_q  <= last_grant_d;
            grant_id_q    <= grant_id_d;
            req_ready_q   <= req_ready_d;
            tx_data_q     <= tx_data_d;
            tx_start_q    <= tx_start_d;
            active_q      <= active_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign grant_id    = grant_id_q;
    assign active      = active_q;
    assign err_timeout = err_timeout_q;
    assign dbg_state_o = state_q;

endmodule
